// File: rtl/button_conditioner.sv
// Player pushbutton front end: 2-FF synchronizer, per-channel debounce and a
// press / auto-repeat FSM per channel, with a lock input that masks everything.
module button_conditioner #(
   parameter int unsigned NUM_BTN         = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000,
   parameter int unsigned CNT_W           = 25
) (
   input  logic               clk,
   input  logic               gameReset,
   input  logic [NUM_BTN-1:0] btn_raw_n,
   input  logic               lock,
   output logic [NUM_BTN-1:0] btn_level_n,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_repeat,
   output logic               any_press
);

   typedef enum logic [1:0] {RELEASED, HELD_DELAY, HELD_REPEAT} chanState_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

   logic [NUM_BTN-1:0] pressNext;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      logic             syncA, syncB, stable, armed;
      logic [CNT_W-1:0] dbCnt, repCnt, repCntNext;
      chanState_t       state, stateNext;
      logic             stableNext, pressN, repeatN;
      logic             levelQ, pressQ, repeatQ;

      // Debounce acceptance is looked ahead so the press pulse and the level
      // change land on the same edge that the stable bit flips.
      assign stableNext = ((syncB != stable) && (dbCnt == DB_LAST)) ? syncB : stable;

      always_comb begin
         stateNext  = state;
         repCntNext = repCnt;
         pressN     = 1'b0;
         repeatN    = 1'b0;
         if (lock || stableNext) begin
            stateNext  = RELEASED;
            repCntNext = '0;
         end else begin
            case (state)
               RELEASED: begin
                  if (stable && !armed) begin
                     stateNext  = HELD_DELAY;
                     repCntNext = '0;
                     pressN     = 1'b1;
                  end
               end
               HELD_DELAY: begin
                  if (repCnt == RD_LAST) begin
                     repeatN    = 1'b1;
                     repCntNext = '0;
                     stateNext  = HELD_REPEAT;
                  end else begin
                     repCntNext = repCnt + CNT_W'(1);
                  end
               end
               HELD_REPEAT: begin
                  if (repCnt == RR_LAST) begin
                     repeatN    = 1'b1;
                     repCntNext = '0;
                  end else begin
                     repCntNext = repCnt + CNT_W'(1);
                  end
               end
               default: stateNext = RELEASED;
            endcase
         end
      end

      always_ff @(posedge clk or negedge gameReset) begin
         if (!gameReset) begin
            syncA   <= 1'b1;
            syncB   <= 1'b1;
            stable  <= 1'b1;
            dbCnt   <= '0;
            armed   <= 1'b0;
            state   <= RELEASED;
            repCnt  <= '0;
            levelQ  <= 1'b1;
            pressQ  <= 1'b0;
            repeatQ <= 1'b0;
         end else begin
            syncA <= btn_raw_n[i];
            syncB <= syncA;
            if (syncB == stable) begin
               dbCnt <= '0;
            end else if (dbCnt == DB_LAST) begin
               stable <= syncB;
               dbCnt  <= '0;
            end else begin
               dbCnt <= dbCnt + CNT_W'(1);
            end
            if (stable) armed <= 1'b0;
            else if (lock) armed <= 1'b1;
            state   <= stateNext;
            repCnt  <= repCntNext;
            levelQ  <= stableNext | lock | (stateNext == RELEASED);
            pressQ  <= pressN;
            repeatQ <= repeatN;
         end
      end

      assign btn_level_n[i] = levelQ;
      assign btn_press[i]   = pressQ;
      assign btn_repeat[i]  = repeatQ;
      assign pressNext[i]   = pressN;
   end

   always_ff @(posedge clk or negedge gameReset) begin
      if (!gameReset) any_press <= 1'b0;
      else            any_press <= |pressNext;
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Receiving end of the player pushbutton interface.
- Takes the raw, asynchronous, active-low board buttons (L, R, G) and delivers clean signals to the game logic:
  - debounced active-low levels, drop-in replacements for the existing pbL/pbR/pbG consumers;
  - single-cycle press pulses;
  - auto-repeat pulses for held buttons.
- Sits between the board pins and playerHandle/bulletHandle, clocked by MAIN_CLK.
- Includes a lock input (driven by endgameLose) that masks all button activity.

Parameters:
- NUM_BTN, 3, number of independent button channels (bit 0 = L, 1 = R, 2 = G).
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a level change (≥2).
- REPEAT_DELAY, 25000000, clk cycles from the press pulse to the first repeat pulse (≥2).
- REPEAT_RATE, 5000000, clk cycles between subsequent repeat pulses (≥2).
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  input  1  MAIN_CLK domain clock.
- gameReset  input  1  Reset: asynchronous, active-low.
- btn_raw_n  input  NUM_BTN  Raw board buttons, asynchronous, 0 = pressed.
- lock  input  1  1 = ignore all buttons (endgameLose).
- btn_level_n  output  NUM_BTN  Debounced, lock-masked level, 0 = pressed.
- btn_press  output  NUM_BTN  1-cycle pulse on accepted press.
- btn_repeat  output  NUM_BTN  1-cycle pulse per auto-repeat interval while held.
- any_press  output  1  OR of btn_press.

Behaviour:
- **Reset (gameReset=0, async):**
  - Synchronizer flops set to 1; stable levels set to 1 (released).
  - All counters cleared; every channel FSM goes to RELEASED.
  - btn_level_n = all 1; btn_press, btn_repeat, any_press = 0.
  - Reset mid-hold: after release of reset, a still-held button must be debounced again and does generate a press pulse.
- **Synchronizer:** 2-FF per channel; sync = second flop.
- **Debounce (per channel):**
  - Registered stable bit plus CNT_W counter.
  - If sync == stable: counter cleared.
  - Else: counter increments. When counter == DEBOUNCE_CYCLES-1 and sync still differs: stable <= sync, counter cleared.
  - Any bounce back to stable before then clears the counter.
  - Latency: a clean raw edge changes stable exactly 2 + DEBOUNCE_CYCLES rising edges later.
- **Channel FSM (per channel), states RELEASED, HELD_DELAY, HELD_REPEAT:**
  - RELEASED → HELD_DELAY on stable 1→0 while lock=0, and while the channel's lock-armed flag is clear. btn_press=1 for that one cycle; repeat counter cleared.
  - HELD_DELAY: counter increments. At counter == REPEAT_DELAY-1: btn_repeat=1 for one cycle, counter cleared, go to HELD_REPEAT.
  - HELD_REPEAT: counter increments. At counter == REPEAT_RATE-1: btn_repeat=1, counter cleared, stay.
  - Any held state → RELEASED immediately when stable=1 (no pulse). A release on the same cycle a repeat would fire suppresses that repeat.
- **Outputs:** btn_level_n = stable OR lock OR (state==RELEASED). Level follows the FSM, so it is low only while an accepted press is held. All outputs are registered.
- **Lock:**
  - While lock=1: btn_level_n forced all 1, no press or repeat pulses, all FSMs forced to RELEASED.
  - Debounce keeps tracking so stable stays current.
  - Lock-armed flag: set for a channel if lock=1 while its stable=0; cleared when stable=1.
  - After lock falls, a button still held produces nothing until it is released and pressed again.
- **Independence and widths:**
  - Channels are fully independent; simultaneous presses on several channels give simultaneous pulses, and any_press is their OR.
  - Counters never wrap: they are cleared on every match, so CNT_W only needs to reach the maxima.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, NUM_BTN=3.)
- **Clean press:** btn_raw_n[0] 1→0 and held → btn_press[0] and btn_level_n[0] fall exactly 6 edges later. One btn_press pulse only, any_press matches, other channels idle.
- **Bounce:** btn_raw_n[1] toggles 0,1,0,1 at 1-cycle spacing, then stays 0 → no pulse during bouncing. Single btn_press[1] 6 edges after the final edge. Release bouncing 1,0,1 → btn_level_n[1] returns to 1 with no pulse.
- **Auto-repeat:** hold btn 2 for 30 cycles after the press pulse → btn_repeat[2] at +10, +13, +16, +19, +22, +25, +28 relative to the press pulse. Release → repeats stop and level returns to 1 after 6 cycles.
- **Lock:** hold btn 0, assert lock → level forced 1 and no repeats. Drop lock while still held → no press. Release then press again → press pulse 6 edges after the new edge.
- **Simultaneous presses:** press L and R on the same edge → btn_press=3'b011 in one cycle, any_press=1 for exactly one cycle.
- **Async reset:** hold btn 2 in HELD_REPEAT, pulse gameReset low mid-cycle → outputs immediately level=3'b111 and pulses 0. After reset release with the button still held → new press pulse 6 edges later.
